ocx_dlx_rx_que: RTL and testbench

Per-lane receive queue for the DLX receive path; inverse of the per-lane transmit queue. Descrambles gearbox data and undoes the transmit bit ordering. During training it recognises TS0/TS1/TS2/TS3/deskew blocks, qualifies them with a consecutive-match lock FSM and checks deskew cadence; after training it forwards flit data to the flit receiver. One instance per lane (8), between the RX gearbox and RX flit/control logic.

---
 rtl/ocx_dlx_rx_que_if.sv | 40 ++++
 rtl/ocx_dlx_rx_que.sv | 137 +++++++++++++
 tb/tb_ocx_dlx_rx_que.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocx_dlx_rx_que_if.sv
// Per-lane receive queue bus: gearbox input, control inputs, and queue outputs.
interface ocx_dlx_rx_que_if;
    logic        ctl_que_reset;
    logic [2:0]  ctl_que_lane;
    logic        ctl_que_train_done;
    logic        ctl_que_use_neighbor;
    logic [63:0] ctl_que_lane_scrambler;
    logic        gb_que_valid;
    logic [63:0] gb_que_data;
    logic [63:0] neighbor_in_data;
    logic [63:0] neighbor_out_data;
    logic [63:0] que_flt_data;
    logic        que_flt_valid;
    logic        que_ctl_locked;
    logic        que_ctl_ts1;
    logic        que_ctl_ts2;
    logic        que_ctl_ts3;
    logic [15:0] que_ctl_good_lanes;
    logic        que_ctl_deskew_det;
    logic [18:0] que_ctl_deskew;
    logic        que_ctl_deskew_err;

    // Driver side: control and gearbox, observes queue outputs.
    modport master (
        output ctl_que_reset, ctl_que_lane, ctl_que_train_done, ctl_que_use_neighbor,
               ctl_que_lane_scrambler, gb_que_valid, gb_que_data, neighbor_in_data,
        input  neighbor_out_data, que_flt_data, que_flt_valid, que_ctl_locked,
               que_ctl_ts1, que_ctl_ts2, que_ctl_ts3, que_ctl_good_lanes,
               que_ctl_deskew_det, que_ctl_deskew, que_ctl_deskew_err
    );

    // Queue side.
    modport slave (
        input  ctl_que_reset, ctl_que_lane, ctl_que_train_done, ctl_que_use_neighbor,
               ctl_que_lane_scrambler, gb_que_valid, gb_que_data, neighbor_in_data,
        output neighbor_out_data, que_flt_data, que_flt_valid, que_ctl_locked,
               que_ctl_ts1, que_ctl_ts2, que_ctl_ts3, que_ctl_good_lanes,
               que_ctl_deskew_det, que_ctl_deskew, que_ctl_deskew_err
    );
endinterface

// File: rtl/ocx_dlx_rx_que.sv
// DLX per-lane receive queue: descramble, undo TX bit order, TS lock FSM,
// deskew cadence check, and flit forwarding after training.
module ocx_dlx_rx_que #(
    parameter int unsigned MATCH_CNT = 2,
    parameter int unsigned ERR_LIMIT = 4
) (
    input logic             dlx_clk,
    input logic             dlx_reset,
    ocx_dlx_rx_que_if.slave bus
);
    localparam int unsigned DW = 64;

    typedef enum logic [2:0] {BLK_TS0, BLK_TS1, BLK_TS2, BLK_TS3, BLK_DSK, BLK_UNREC} blk_e;
    typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

    logic [DW-1:0] d_w, f_w, p_w;
    blk_e          blk;
    logic [2:0]    blk_oh;
    logic [2:0]    mcnt_d, miss_d;
    logic          lock_hit, miss_hit;

    state_e        state_q;
    logic [2:0]    cand_q, mcnt_q, miss_q, ts_q;
    logic          locked_q;
    logic [15:0]   good_lanes_q;
    logic [4:0]    dcnt_q;
    logic          seen_q;
    logic          det_q, err_q;
    logic [18:0]   deskew_q;
    logic [DW-1:0] flt_data_q;
    logic          flt_valid_q;

    // Descramble, full bit reversal for flits, per-byte reversal for patterns.
    always_comb begin
        d_w = bus.gb_que_data ^ bus.ctl_que_lane_scrambler;
        for (int i = 0; i < 64; i++) f_w[i] = d_w[63-i];
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++) p_w[8*j+k] = d_w[8*j+7-k];
    end

    // Block classification and candidate/miss counter next values.
    always_comb begin
        blk = BLK_UNREC;
        if (p_w == 64'h0)                                      blk = BLK_TS0;
        else if (p_w == 64'h4B4A4A4A4A4A4A4A)                  blk = BLK_TS1;
        else if (p_w[63:16] == 48'h4B4545454545)               blk = BLK_TS2;
        else if (p_w[63:16] == 48'h4B4141414141)               blk = BLK_TS3;
        else if (p_w[63:24] == 40'h4B1E1E1E1E && p_w[4:3] == 2'b00) blk = BLK_DSK;
        blk_oh = 3'b000;
        case (blk)
            BLK_TS1: blk_oh = 3'b001;
            BLK_TS2: blk_oh = 3'b010;
            BLK_TS3: blk_oh = 3'b100;
            default: blk_oh = 3'b000;
        endcase
        if (blk_oh == cand_q) mcnt_d = (mcnt_q == 3'd7) ? mcnt_q : mcnt_q + 3'd1;
        else                  mcnt_d = 3'd1;
        miss_d   = (miss_q == 3'd7) ? miss_q : miss_q + 3'd1;
        lock_hit = (mcnt_d >= 3'(MATCH_CNT));
        miss_hit = (miss_d >= 3'(ERR_LIMIT));
    end

    // Lock FSM, deskew checker and flit output register.
    always_ff @(posedge dlx_clk or posedge dlx_reset) begin
        if (dlx_reset) begin
            state_q <= ST_HUNT;  cand_q <= '0;   mcnt_q <= '0;  miss_q <= '0;
            ts_q <= '0;          locked_q <= 1'b0; good_lanes_q <= '0;
            dcnt_q <= '0;        seen_q <= 1'b0; det_q <= 1'b0; err_q <= 1'b0;
            deskew_q <= '0;      flt_data_q <= '0; flt_valid_q <= 1'b0;
        end else if (bus.ctl_que_reset) begin
            state_q <= ST_HUNT;  cand_q <= '0;   mcnt_q <= '0;  miss_q <= '0;
            ts_q <= '0;          locked_q <= 1'b0; good_lanes_q <= '0;
            dcnt_q <= '0;        seen_q <= 1'b0; det_q <= 1'b0; err_q <= 1'b0;
            deskew_q <= '0;      flt_data_q <= '0; flt_valid_q <= 1'b0;
        end else begin
            det_q       <= 1'b0;
            err_q       <= 1'b0;
            flt_valid_q <= bus.ctl_que_train_done & bus.gb_que_valid;
            if (bus.gb_que_valid) begin
                if (bus.ctl_que_train_done) begin
                    flt_data_q <= bus.ctl_que_use_neighbor ? bus.neighbor_in_data : f_w;
                end else begin
                    if (blk == BLK_DSK) begin
                        det_q    <= 1'b1;
                        deskew_q <= p_w[23:5];
                        err_q    <= (p_w[2:0] != bus.ctl_que_lane) || (seen_q && dcnt_q != 5'd31);
                        dcnt_q   <= '0;
                        seen_q   <= 1'b1;
                    end else if (dcnt_q != 5'd31) begin
                        dcnt_q <= dcnt_q + 5'd1;
                    end

                    if (state_q == ST_LOCKED && blk_oh != 3'b000 && blk_oh == ts_q) begin
                        miss_q <= '0;
                        mcnt_q <= '0;
                        if (!blk_oh[0]) good_lanes_q <= p_w[15:0];
                    end else if (blk_oh != 3'b000) begin
                        cand_q <= blk_oh;
                        mcnt_q <= mcnt_d;
                        if (lock_hit) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            ts_q     <= blk_oh;
                            miss_q   <= '0;
                            mcnt_q   <= '0;
                            if (!blk_oh[0]) good_lanes_q <= p_w[15:0];
                        end
                    end else if (blk != BLK_DSK) begin
                        mcnt_q <= '0;
                        if (state_q == ST_LOCKED) begin
                            if (miss_hit) begin
                                state_q  <= ST_HUNT;
                                locked_q <= 1'b0;
                                ts_q     <= '0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= miss_d;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.neighbor_out_data  = f_w;
    assign bus.que_flt_data       = flt_data_q;
    assign bus.que_flt_valid      = flt_valid_q;
    assign bus.que_ctl_locked     = locked_q;
    assign bus.que_ctl_ts1        = ts_q[0];
    assign bus.que_ctl_ts2        = ts_q[1];
    assign bus.que_ctl_ts3        = ts_q[2];
    assign bus.que_ctl_good_lanes = good_lanes_q;
    assign bus.que_ctl_deskew_det = det_q;
    assign bus.que_ctl_deskew     = deskew_q;
    assign bus.que_ctl_deskew_err = err_q;
endmodule

// File: tb/tb_ocx_dlx_rx_que.sv
// Bench for ocx_dlx_rx_que: directed blocks, behavioural model, per-cycle compare.
module tb_ocx_dlx_rx_que;
    localparam int MATCH = 2;
    localparam int ERRL  = 4;

    logic dlx_clk = 1'b0;
    logic dlx_reset = 1'b0;
    logic check_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ocx_dlx_rx_que_if ifc();

    ocx_dlx_rx_que #(.MATCH_CNT(MATCH), .ERR_LIMIT(ERRL)) dut (
        .dlx_clk  (dlx_clk),
        .dlx_reset(dlx_reset),
        .bus      (ifc.slave)
    );

    always #5 dlx_clk = ~dlx_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] bitrev(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [63:0] byterev(input logic [63:0] x);
        logic [63:0] r;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++) r[8*j+k] = x[8*j+7-k];
        return r;
    endfunction

    // 0..3 = TS0..TS3, 4 = deskew, 5 = unrecognised
    function automatic int classify(input logic [63:0] p);
        if (p == 64'h0) return 0;
        if (p == 64'h4B4A4A4A4A4A4A4A) return 1;
        if (p[63:16] == 48'h4B4545454545) return 2;
        if (p[63:16] == 48'h4B4141414141) return 3;
        if (p[63:24] == 40'h4B1E1E1E1E && p[4:3] == 2'b00) return 4;
        return 5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state
    int          m_locked = 0, m_ts = 0, m_cand = 0, m_run = 0, m_miss = 0;
    int          m_dcnt = 0, m_seen = 0;
    logic [63:0] m_fdata = '0;
    logic        m_fvalid = 1'b0, m_det = 1'b0, m_err = 1'b0;
    logic [15:0] m_gl = '0;
    logic [18:0] m_dsk = '0;

    // Behavioural model of the lane queue rules.
    always @(posedge dlx_clk or posedge dlx_reset) begin : model
        int lk, ty, cd, rn, ms, dc, sn, k;
        logic [63:0] d, p, fd;
        logic fv, det, err;
        logic [15:0] gl;
        logic [18:0] dk;
        if (dlx_reset) begin
            m_locked <= 0; m_ts <= 0; m_cand <= 0; m_run <= 0; m_miss <= 0;
            m_dcnt <= 0; m_seen <= 0; m_fdata <= '0; m_fvalid <= 1'b0;
            m_det <= 1'b0; m_err <= 1'b0; m_gl <= '0; m_dsk <= '0;
        end else begin
            lk = m_locked; ty = m_ts; cd = m_cand; rn = m_run; ms = m_miss;
            dc = m_dcnt; sn = m_seen; fd = m_fdata; gl = m_gl; dk = m_dsk;
            det = 1'b0; err = 1'b0; fv = 1'b0;
            d = ifc.gb_que_data ^ ifc.ctl_que_lane_scrambler;
            p = byterev(d);
            if (ifc.ctl_que_reset) begin
                lk = 0; ty = 0; cd = 0; rn = 0; ms = 0; dc = 0; sn = 0;
                fd = '0; gl = '0; dk = '0;
            end else begin
                fv = ifc.ctl_que_train_done & ifc.gb_que_valid;
                if (ifc.gb_que_valid && ifc.ctl_que_train_done) begin
                    fd = ifc.ctl_que_use_neighbor ? ifc.neighbor_in_data : bitrev(d);
                end else if (ifc.gb_que_valid) begin
                    k = classify(p);
                    if (k == 4) begin
                        det = 1'b1;
                        dk  = p[23:5];
                        err = (p[2:0] != ifc.ctl_que_lane) || (sn != 0 && dc != 31);
                        dc  = 0;
                        sn  = 1;
                    end else if (dc < 31) begin
                        dc++;
                    end
                    if (k >= 1 && k <= 3) begin
                        if (lk != 0 && k == ty) begin
                            ms = 0; rn = 0;
                            if (k > 1) gl = p[15:0];
                        end else begin
                            if (k == cd) rn++;
                            else begin cd = k; rn = 1; end
                            if (rn >= MATCH) begin
                                lk = 1; ty = k; ms = 0; rn = 0;
                                if (k > 1) gl = p[15:0];
                            end
                        end
                    end else if (k != 4) begin
                        rn = 0;
                        if (lk != 0) begin
                            ms++;
                            if (ms >= ERRL) begin lk = 0; ty = 0; ms = 0; end
                        end
                    end
                end
            end
            m_locked <= lk; m_ts <= ty; m_cand <= cd; m_run <= rn; m_miss <= ms;
            m_dcnt <= dc; m_seen <= sn; m_fdata <= fd; m_fvalid <= fv;
            m_det <= det; m_err <= err; m_gl <= gl; m_dsk <= dk;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge dlx_clk) begin
        if (check_en) begin
            chk("flt_data",   ifc.que_flt_data, m_fdata);
            chk("flt_valid",  64'(ifc.que_flt_valid), 64'(m_fvalid));
            chk("locked",     64'(ifc.que_ctl_locked), 64'(m_locked != 0));
            chk("ts1",        64'(ifc.que_ctl_ts1), 64'(m_ts == 1));
            chk("ts2",        64'(ifc.que_ctl_ts2), 64'(m_ts == 2));
            chk("ts3",        64'(ifc.que_ctl_ts3), 64'(m_ts == 3));
            chk("good_lanes", 64'(ifc.que_ctl_good_lanes), 64'(m_gl));
            chk("deskew_det", 64'(ifc.que_ctl_deskew_det), 64'(m_det));
            chk("deskew",     64'(ifc.que_ctl_deskew), 64'(m_dsk));
            chk("deskew_err", 64'(ifc.que_ctl_deskew_err), 64'(m_err));
            chk("nbr_out",    ifc.neighbor_out_data,
                bitrev(ifc.gb_que_data ^ ifc.ctl_que_lane_scrambler));
        end
    end

    task automatic send(input logic [63:0] gb, input logic v, input logic [63:0] scr);
        ifc.gb_que_data            = gb;
        ifc.gb_que_valid           = v;
        ifc.ctl_que_lane_scrambler = scr;
        @(posedge dlx_clk);
        #1;
    endtask

    task automatic send_pat(input logic [63:0] p);
        logic [63:0] scr;
        scr = {$urandom, $urandom} | 64'h1;
        send(byterev(p) ^ scr, 1'b1, scr);
    endtask

    task automatic send_flit(input logic [63:0] f);
        logic [63:0] scr;
        scr = {$urandom, $urandom} | 64'h1;
        send(bitrev(f) ^ scr, 1'b1, scr);
    endtask

    localparam logic [63:0] P_TS1 = 64'h4B4A4A4A4A4A4A4A;
    localparam logic [63:0] P_UNR = 64'h0123456789ABCDEF;

    function automatic logic [63:0] p_ts2(input logic [15:0] g);
        return {48'h4B4545454545, g};
    endfunction
    function automatic logic [63:0] p_ts3(input logic [15:0] g);
        return {48'h4B4141414141, g};
    endfunction
    function automatic logic [63:0] p_dsk(input logic [18:0] f, input logic [2:0] ln);
        return {40'h4B1E1E1E1E, f, 2'b00, ln};
    endfunction

    initial begin
        logic [63:0] sc;
        ifc.ctl_que_reset = 1'b0;  ifc.ctl_que_lane = 3'd5;
        ifc.ctl_que_train_done = 1'b0; ifc.ctl_que_use_neighbor = 1'b0;
        ifc.ctl_que_lane_scrambler = '0; ifc.gb_que_valid = 1'b0;
        ifc.gb_que_data = '0; ifc.neighbor_in_data = '0;
        #1 dlx_reset = 1'b1;
        #21 dlx_reset = 1'b0;
        @(posedge dlx_clk); #1;
        check_en = 1'b1;
        chk("rst_locked", 64'(ifc.que_ctl_locked), 64'd0);
        chk("rst_flt_data", ifc.que_flt_data, 64'd0);

        // 1: TS1 lock with zero scrambler, literal gearbox word
        send(64'hD252525252525252, 1'b1, 64'h0);
        chk("t1_locked_after1", 64'(ifc.que_ctl_locked), 64'd0);
        send(64'hD252525252525252, 1'b1, 64'h0);
        chk("t1_locked_after2", 64'(ifc.que_ctl_locked), 64'd1);
        chk("t1_ts1", 64'(ifc.que_ctl_ts1), 64'd1);

        // 2: switch to TS2 with scrambling
        send_pat(p_ts2(16'h00FF));
        chk("t2_ts1_still", 64'(ifc.que_ctl_ts1), 64'd1);
        chk("t2_locked_mid", 64'(ifc.que_ctl_locked), 64'd1);
        send_pat(p_ts2(16'h00FF));
        chk("t2_ts2", 64'(ifc.que_ctl_ts2), 64'd1);
        chk("t2_ts1", 64'(ifc.que_ctl_ts1), 64'd0);
        chk("t2_gl", 64'(ifc.que_ctl_good_lanes), 64'h00FF);
        chk("t2_locked", 64'(ifc.que_ctl_locked), 64'd1);

        // 3: TS3 lock and deskew cadence
        send_pat(p_ts3(16'h0F0F));
        send_pat(p_ts3(16'h0F0F));
        chk("t3_ts3", 64'(ifc.que_ctl_ts3), 64'd1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 31; i++) send_pat(p_ts3(16'h0F0F));
            send_pat(p_dsk(19'h12345, 3'd5));
            chk("t3_det", 64'(ifc.que_ctl_deskew_det), 64'd1);
            chk("t3_dsk", 64'(ifc.que_ctl_deskew), 64'h12345);
            chk("t3_noerr", 64'(ifc.que_ctl_deskew_err), 64'd0);
            send_pat(p_ts3(16'h0F0F));
            chk("t3_det_pulse", 64'(ifc.que_ctl_deskew_det), 64'd0);
        end
        for (int i = 0; i < 29; i++) send_pat(p_ts3(16'h0F0F));
        send_pat(p_dsk(19'h12345, 3'd5));
        chk("t3_cadence_err", 64'(ifc.que_ctl_deskew_err), 64'd1);
        for (int i = 0; i < 31; i++) send_pat(p_ts3(16'h0F0F));
        send_pat(p_dsk(19'h12345, 3'd3));
        chk("t3_lane_err", 64'(ifc.que_ctl_deskew_err), 64'd1);
        chk("t3_still_ts3", 64'(ifc.que_ctl_ts3), 64'd1);

        // 4: unrecognised blocks with stalls
        send_pat(P_TS1);
        send_pat(P_TS1);
        chk("t4_ts1", 64'(ifc.que_ctl_ts1), 64'd1);
        for (int i = 0; i < 4; i++) begin
            send_pat(P_UNR);
            chk("t4_locked_unrec", 64'(ifc.que_ctl_locked), 64'(i < 3));
            send(64'hFFFF0000FFFF0000, 1'b0, 64'h0);
            chk("t4_locked_stall", 64'(ifc.que_ctl_locked), 64'(i < 3));
        end

        // 5: flit mode, own lane then neighbour
        send_pat(p_ts2(16'hA0A0));
        send_pat(p_ts2(16'hA0A0));
        ifc.ctl_que_train_done = 1'b1;
        sc = 64'h5A5A_1234_DEAD_BEEF;
        ifc.gb_que_data = bitrev(64'h0123456789ABCDEF) ^ sc;
        ifc.ctl_que_lane_scrambler = sc;
        ifc.gb_que_valid = 1'b1;
        #1;
        chk("t5_nbr_out", ifc.neighbor_out_data, 64'h0123456789ABCDEF);
        chk("t5_valid_pre", 64'(ifc.que_flt_valid), 64'd0);
        @(posedge dlx_clk); #1;
        chk("t5_flt_data", ifc.que_flt_data, 64'h0123456789ABCDEF);
        chk("t5_flt_valid", 64'(ifc.que_flt_valid), 64'd1);
        chk("t5_locked_kept", 64'(ifc.que_ctl_locked), 64'd1);
        send(64'h0, 1'b0, 64'h0);
        chk("t5_stall_valid", 64'(ifc.que_flt_valid), 64'd0);
        chk("t5_stall_hold", ifc.que_flt_data, 64'h0123456789ABCDEF);
        ifc.ctl_que_use_neighbor = 1'b1;
        ifc.neighbor_in_data = 64'hA5A5A5A5A5A5A5A5;
        send_flit(64'h1122334455667788);
        chk("t5_nbr_data", ifc.que_flt_data, 64'hA5A5A5A5A5A5A5A5);
        ifc.ctl_que_use_neighbor = 1'b0;
        send_flit(64'hCAFEF00D00C0FFEE);
        chk("t5_own_again", ifc.que_flt_data, 64'hCAFEF00D00C0FFEE);

        // 6: asynchronous reset mid-flit, then synchronous soft reset
        #3 dlx_reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(ifc.que_flt_valid), 64'd0);
        chk("t6_async_data", ifc.que_flt_data, 64'd0);
        chk("t6_async_locked", 64'(ifc.que_ctl_locked), 64'd0);
        chk("t6_async_gl", 64'(ifc.que_ctl_good_lanes), 64'd0);
        #2 dlx_reset = 1'b0;
        @(posedge dlx_clk); #1;
        ifc.ctl_que_train_done = 1'b0;
        send_pat(P_TS1);
        send_pat(P_TS1);
        chk("t6_relock", 64'(ifc.que_ctl_locked), 64'd1);
        ifc.ctl_que_reset = 1'b1;
        send_pat(P_TS1);
        ifc.ctl_que_reset = 1'b0;
        chk("t6_soft_locked", 64'(ifc.que_ctl_locked), 64'd0);
        chk("t6_soft_ts1", 64'(ifc.que_ctl_ts1), 64'd0);
        chk("t6_soft_data", ifc.que_flt_data, 64'd0);
        send(64'h0, 1'b0, 64'h0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
